ifetch_ctrl: RTL
================

Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer in front of the combinational, read-only instruction memory (1024 x 32-bit words).
- Owns the program counter and drives the fetch byte address.
- Captures each returned word, tagged with its PC, into a small prefetch FIFO.
- Presents FIFO entries to decode over a valid/ready handshake.
- Handles start/halt, redirect (branch/jump) flushes and fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- MEM_WORDS, 1024, instruction memory size in words; legal fetch range is 0 to MEM_WORDS*4-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; IDLE -> RUN.
- halt  in  1  level; while high, no new fetches are issued.
- redirect  in  1  single-cycle pulse; flush FIFO and load redirect_pc.
- redirect_pc  in  32  new fetch PC.
- imem_addr  out  32  byte address to instruction memory; combinational from pc.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- if_valid  out  1  FIFO head valid.
- if_instr  out  32  head instruction.
- if_pc  out  32  head PC.
- id_ready  in  1  decode accepts head.
- busy  out  1  state is RUN.
- fault  out  1  fetch fault sticky flag.
- fault_pc  out  32  PC that faulted.

Behaviour:
- Reset values: pc=RESET_PC, FIFO empty, if_valid=0, if_instr=0, if_pc=0, busy=0, fault=0, fault_pc=0, state=IDLE. imem_addr tracks pc.
- State machine:
  - IDLE: no fetch. start -> RUN.
  - RUN: fetch when fetch_ok. halt -> IDLE. Bad pc -> FAULT.
  - FAULT: no fetch; fault=1, fault_pc latched. redirect -> RUN with the new pc; fault clears.
  - start is ignored outside IDLE.
- fetch_ok = RUN && !halt && !redirect && (count<DEPTH || pop).
- On fetch_ok: push {pc, imem_data} into the FIFO; pc <= pc+4 (32-bit wrap is irrelevant; range fault occurs first).
- Bad pc: pc[1:0]!=0 or pc >= MEM_WORDS*4.
  - Checked in RUN before the push.
  - Bad pc -> no push, fault_pc<=pc, fault<=1, next state FAULT.
  - FIFO contents before the fault still drain to decode.
- pop = if_valid && id_ready.
  - Push and pop in the same cycle are legal at full.
  - Count is unchanged in that case.
- Latency: a word fetched at edge N is visible on if_valid/if_instr at N+1 when the FIFO was empty. There is no combinational path from imem_data to if_instr.
- Redirect (any state):
  - Flush the FIFO (count=0, if_valid=0 next cycle); pc<=redirect_pc.
  - No push in the redirect cycle, even if decode pops in that cycle.
  - Fetching resumes the next cycle when in RUN: one-cycle bubble.
  - In IDLE, redirect only updates pc; state stays IDLE.
  - In FAULT, redirect clears fault and fault_pc=0, then -> RUN.
- redirect takes priority over start and halt in the same cycle. start+redirect in IDLE: pc<=redirect_pc and state -> RUN.
- halt in RUN -> IDLE next edge; the FIFO is retained and continues draining. A later start resumes at the current pc.
- busy = (state==RUN).
- Reset asserted mid-operation returns every register to its reset value immediately. In-flight FIFO contents are discarded.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (increments on every push) and perf_flush_cnt[31:0] (increments on every redirect that discards count>0 entries).
  - Both are 0 on reset and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, start, id_ready=1, imem word[i]=i+0x100 -> if_valid from cycle 2; if_pc 0,4,8,... with if_instr 0x100,0x101,...; one entry per cycle, no gaps.
2. id_ready=0 for 10 cycles after start -> exactly 4 pushes, pc stops at 0x10, imem_addr held at 0x10; then id_ready=1 -> 0,4,8,0xC then 0x10 in order.
3. In RUN with 3 entries queued, redirect to 0x200 -> if_valid=0 next cycle; next delivered if_pc=0x200, with no stale 0x00-0x0C entries.
4. redirect_pc=0x0FFC, run -> 0xFFC delivered; the fetch at 0x1000 sets fault=1, fault_pc=0x1000, busy=0; redirect to 0x40 clears fault and resumes at 0x40.
5. redirect_pc=0x6 while in RUN -> fault=1, fault_pc=0x6 the next cycle, no push; earlier entries still drain.
6. Assert halt for 5 cycles then pulse start -> no imem push during halt; fetch resumes at the held pc. Async rst pulse mid-stream -> if_valid=0 and pc=RESET_PC immediately.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, prefetches into a small FIFO, hands words to decode.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        busy,
  output logic        fault,
  output logic [31:0] fault_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int          PW        = $clog2(DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_t;

  state_t        state, state_next;
  logic [31:0]   pc;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic bad_pc, try_fetch, fetch_ok, fault_set, pop;

  assign imem_addr = pc;
  assign busy      = (state == ST_RUN);
  assign if_valid  = (count != '0);
  assign pop       = if_valid && id_ready;
  // Gate the head with valid so the unreset storage never leaks X onto the outputs.
  assign if_instr  = if_valid ? instr_mem[rd_ptr] : '0;
  assign if_pc     = if_valid ? pc_mem[rd_ptr]    : '0;
  assign bad_pc    = (pc[1:0] != 2'b00) || ({1'b0, pc} >= MEM_BYTES);

  // NOTE: every output of an always_comb gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    try_fetch  = 1'b0;
    fetch_ok   = 1'b0;
    fault_set  = 1'b0;
    state_next = state;
    try_fetch  = (state == ST_RUN) && !halt && !redirect;
    fault_set  = try_fetch && bad_pc;
    fetch_ok   = try_fetch && !bad_pc && ((count < (PW+1)'(DEPTH)) || pop);
    if (redirect) begin
      state_next = (state == ST_IDLE && !start) ? ST_IDLE : ST_RUN;
    end else begin
      unique case (state)
        ST_IDLE:  if (start) state_next = ST_RUN;
        ST_RUN:   if (halt) state_next = ST_IDLE;
                  else if (bad_pc) state_next = ST_FAULT;
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state <= state_next;
      if (redirect)      pc <= redirect_pc;
      else if (fetch_ok) pc <= pc + 32'd4;
      if (redirect) begin
        fault    <= 1'b0;
        fault_pc <= '0;
      end else if (fault_set) begin
        fault    <= 1'b1;
        fault_pc <= pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      unique case ({fetch_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (fetch_ok) begin
      instr_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]    <= pc;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (fetch_ok)                     perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect && (count != '0))    perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
